// File: rtl/y86_pkg.sv
// Shared loader definitions: FSM states, error codes, frame header sizes and the
// running checksum helper used by imem_loader.
package y86_pkg;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_ENTRY = 3'd1,
        ST_DATA  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_ENTRY = 2'd2;
    localparam logic [1:0] ERR_CKSUM = 2'd3;

    localparam int LEN_BYTES   = 2;
    localparam int ENTRY_BYTES = 8;

    // Modulo-256 accumulation over every frame byte.
    function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_loader_le_shift_capture.sv
// Little-endian field accumulator: bytes enter at the top and shift down, so after
// NBYTES accepted bytes the first one sits in the least significant position.
module le_shift_capture #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [7:0]            din,
    output logic [8*NBYTES-1:0]   value,
    output logic [8*NBYTES-1:0]   value_next,
    output logic                  done
);
    localparam int CW = $clog2(NBYTES + 1);

    logic [CW-1:0]        cnt_r;
    logic [8*NBYTES-1:0]  value_r;
    logic                 done_s;

    // done marks the edge that completes the field, so the caller can decide on value_next.
    assign value_next = {din, value_r[8*NBYTES-1:8]};
    assign done_s     = en && (cnt_r == CW'(NBYTES - 1));
    assign done       = done_s;
    assign value      = value_r;

    // Field shift register and byte position counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            value_r <= '0;
        end else if (clr) begin
            cnt_r   <= '0;
            value_r <= '0;
        end else if (en) begin
            value_r <= value_next;
            cnt_r   <= done_s ? '0 : cnt_r + CW'(1);
        end else begin
            value_r <= value_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a framed Y86 image into instruction memory, then releases the core.
// Define IMEM_LOADER_CKSUM_EN to require a trailing checksum byte after the payload.
module imem_loader
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LOAD_BASE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        run,
    output logic [63:0] start_pc,
    output logic [15:0] bytes_loaded,
    output logic        load_err,
    output logic [1:0]  err_code
);

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_e POST_DATA = ST_CKSUM;
`else
    localparam state_e POST_DATA = ST_DONE;
`endif

    state_e       state_r, state_nxt_s;
    logic [1:0]   err_code_r, err_nxt_s;
    logic         in_ready_r, run_r, load_err_r, mem_we_r;
    logic [63:0]  mem_addr_r;
    logic [7:0]   mem_wdata_r;
    logic [15:0]  bytes_loaded_r;

    logic         accept_s, restart_s, data_acc_s, data_last_s;
    logic         len_en_s, len_done_s, pc_en_s, pc_done_s;
    logic [15:0]  len_s, len_nxt_s;
    logic [63:0]  pc_s, pc_nxt_s, base_s, img_end_s;

    assign accept_s    = in_valid && in_ready_r;
    assign restart_s   = restart && ((state_r == ST_DONE) || (state_r == ST_ERR));
    assign len_en_s    = accept_s && (state_r == ST_LEN);
    assign pc_en_s     = accept_s && (state_r == ST_ENTRY);
    assign data_acc_s  = accept_s && (state_r == ST_DATA);
    assign data_last_s = data_acc_s && ((bytes_loaded_r + 16'd1) == len_s);
    assign base_s      = 64'(LOAD_BASE);
    assign img_end_s   = base_s + 64'(len_s);

    le_shift_capture #(.NBYTES(LEN_BYTES)) u_len (
        .clk        (clk),
        .rst        (reset),
        .clr        (restart_s),
        .en         (len_en_s),
        .din        (in_data),
        .value      (len_s),
        .value_next (len_nxt_s),
        .done       (len_done_s)
    );

    le_shift_capture #(.NBYTES(ENTRY_BYTES)) u_entry (
        .clk        (clk),
        .rst        (reset),
        .clr        (restart_s),
        .en         (pc_en_s),
        .din        (in_data),
        .value      (pc_s),
        .value_next (pc_nxt_s),
        .done       (pc_done_s)
    );

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] sum_r;

    // Running sum over LEN, ENTRY and PAYLOAD bytes; the CKSUM byte is folded in by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r <= 8'h00;
        end else if (restart_s) begin
            sum_r <= 8'h00;
        end else if (accept_s && (state_r != ST_CKSUM)) begin
            sum_r <= cksum_add(sum_r, in_data);
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    // Frame sequencing; length and entry checks are judged on the byte that completes the field.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = err_code_r;
        case (state_r)
            ST_LEN: begin
                if (len_done_s) begin
                    if ((base_s + 64'(len_nxt_s)) > 64'(MEM_BYTES)) begin
                        state_nxt_s = ST_ERR;
                        err_nxt_s   = ERR_LEN;
                    end else begin
                        state_nxt_s = ST_ENTRY;
                    end
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_ENTRY: begin
                if (pc_done_s) begin
                    if ((pc_nxt_s < base_s) || (pc_nxt_s >= img_end_s)) begin
                        state_nxt_s = ST_ERR;
                        err_nxt_s   = ERR_ENTRY;
                    end else if (len_s == 16'd0) begin
                        state_nxt_s = POST_DATA;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_ENTRY;
                end
            end
            ST_DATA: begin
                if (data_last_s) begin
                    state_nxt_s = POST_DATA;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (accept_s) begin
                    if (cksum_add(sum_r, in_data) == 8'h00) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ERR;
                        err_nxt_s   = ERR_CKSUM;
                    end
                end else begin
                    state_nxt_s = ST_CKSUM;
                end
`else
                state_nxt_s = ST_LEN;
                err_nxt_s   = ERR_NONE;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (restart_s) begin
                    state_nxt_s = ST_LEN;
                    err_nxt_s   = ERR_NONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_LEN;
                err_nxt_s   = ERR_NONE;
            end
        endcase
    end

    // State, status flags and the one-cycle-delayed memory write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_LEN;
            err_code_r     <= ERR_NONE;
            in_ready_r     <= 1'b1;
            run_r          <= 1'b0;
            load_err_r     <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= 64'd0;
            mem_wdata_r    <= 8'h00;
            bytes_loaded_r <= 16'd0;
        end else begin
            state_r    <= state_nxt_s;
            err_code_r <= err_nxt_s;
            in_ready_r <= (state_nxt_s == ST_LEN) || (state_nxt_s == ST_ENTRY) ||
                          (state_nxt_s == ST_DATA) || (state_nxt_s == ST_CKSUM);
            run_r      <= (state_nxt_s == ST_DONE);
            load_err_r <= (state_nxt_s == ST_ERR);
            mem_we_r   <= data_acc_s;
            if (data_acc_s) begin
                mem_addr_r     <= base_s + 64'(bytes_loaded_r);
                mem_wdata_r    <= in_data;
                bytes_loaded_r <= bytes_loaded_r + 16'd1;
            end else if (restart_s) begin
                mem_addr_r     <= mem_addr_r;
                mem_wdata_r    <= mem_wdata_r;
                bytes_loaded_r <= 16'd0;
            end else begin
                mem_addr_r     <= mem_addr_r;
                mem_wdata_r    <= mem_wdata_r;
                bytes_loaded_r <= bytes_loaded_r;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign run          = run_r;
    assign load_err     = load_err_r;
    assign err_code     = err_code_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign bytes_loaded = bytes_loaded_r;
    assign start_pc     = pc_s;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand-written corner sequences and
// random frames judged by a frame-level reference model.
module tb_imem_loader;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned LOAD_BASE = 32;
`ifdef IMEM_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        run;
    logic [63:0] start_pc;
    logic [15:0] bytes_loaded;
    logic        load_err;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;
    int we_count = 0;
    int we_base = 0;
    logic [7:0] pay_q[$];

    typedef struct {
        string       name;
        logic [15:0] len;
        logic [63:0] entry;
        int          gap;
        logic [1:0]  exp_err;
    } vec_t;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .LOAD_BASE(LOAD_BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .run(run), .start_pc(start_pc),
        .bytes_loaded(bytes_loaded), .load_err(load_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) we_count++;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Frame-level rules: overflow first, then entry range, otherwise a clean load.
    function automatic logic [1:0] model_err(input logic [15:0] len, input logic [63:0] entry);
        if (LOAD_BASE + int'(len) > MEM_BYTES) return 2'd1;
        if (entry < 64'(LOAD_BASE) || entry >= 64'(LOAD_BASE) + 64'(len)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic check_reset_outputs(input string nm);
        chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
        chk({nm, ".mem_we"}, 64'(mem_we), 64'd0);
        chk({nm, ".mem_addr"}, mem_addr, 64'd0);
        chk({nm, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({nm, ".run"}, 64'(run), 64'd0);
        chk({nm, ".start_pc"}, start_pc, 64'd0);
        chk({nm, ".bytes_loaded"}, 64'(bytes_loaded), 64'd0);
        chk({nm, ".load_err"}, 64'(load_err), 64'd0);
        chk({nm, ".err_code"}, 64'(err_code), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pay,
                             input int k, output bit ok);
        for (int g = 0; g < 8 && gap > 0 && $urandom_range(0, 99) < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            ok = 1'b0;
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            in_valid = 1'b0;
            ok = 1'b1;
            if (pay) begin
                chk($sformatf("wr%0d.we", k), 64'(mem_we), 64'd1);
                chk($sformatf("wr%0d.addr", k), mem_addr, 64'(LOAD_BASE) + 64'(k));
                chk($sformatf("wr%0d.data", k), 64'(mem_wdata), 64'(b));
                chk($sformatf("wr%0d.cnt", k), 64'(bytes_loaded), 64'(k + 1));
            end else begin
                chk("hdr.no_we", 64'(mem_we), 64'd0);
            end
        end
    endtask

    // poke_at: byte index before which restart (or reset, which ends the frame) is pulsed.
    task automatic send_frame(input logic [15:0] len, input logic [63:0] entry, input int gap,
                              input int ck_delta, input int poke_at, input bit poke_reset);
        logic [7:0] q[$];
        logic [7:0] sum;
        logic [7:0] ck_byte;
        bit ok;
        sum = 8'h00;
        for (int i = 0; i < 2; i++) q.push_back(len[8*i +: 8]);
        for (int i = 0; i < 8; i++) q.push_back(entry[8*i +: 8]);
        for (int i = 0; i < int'(len); i++) q.push_back(pay_q[i]);
        foreach (q[i]) sum = sum + q[i];
        ck_byte = 8'(32'(0) - 32'(sum) + ck_delta);
        if (CK_EN) q.push_back(ck_byte);
        we_base = we_count;
        for (int i = 0; i < q.size(); i++) begin
            if (i == poke_at && poke_reset) begin
                reset = 1'b1;
                #1;
                check_reset_outputs("rst_mid");
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            if (i == poke_at) begin
                restart = 1'b1;
                @(negedge clk);
                restart = 1'b0;
            end
            send_byte(q[i], gap, (i >= 10) && (i < 10 + int'(len)), i - 10, ok);
            if (!ok) break;
        end
    endtask

    task automatic finish_frame(input string nm, input logic [15:0] len,
                                input logic [63:0] entry, input logic [1:0] e);
        int exp_wr;
        exp_wr = (e == 2'd0 || e == 2'd3) ? int'(len) : 0;
        @(negedge clk);
        chk({nm, ".run"}, 64'(run), 64'(e == 2'd0));
        chk({nm, ".load_err"}, 64'(load_err), 64'(e != 2'd0));
        chk({nm, ".err_code"}, 64'(err_code), 64'(e));
        chk({nm, ".in_ready"}, 64'(in_ready), 64'd0);
        chk({nm, ".mem_we_idle"}, 64'(mem_we), 64'd0);
        chk({nm, ".bytes_loaded"}, 64'(bytes_loaded), 64'(exp_wr));
        chk({nm, ".we_pulses"}, 64'(we_count - we_base), 64'(exp_wr));
        if (e == 2'd0) chk({nm, ".start_pc"}, start_pc, entry);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({nm, ".rs_run"}, 64'(run), 64'd0);
        chk({nm, ".rs_err"}, 64'(load_err), 64'd0);
        chk({nm, ".rs_code"}, 64'(err_code), 64'd0);
        chk({nm, ".rs_bytes"}, 64'(bytes_loaded), 64'd0);
        chk({nm, ".rs_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic fill_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    initial begin
        vec_t vecs[12];
        logic [15:0] rlen;
        logic [63:0] rentry;
        int mode;

        vecs[0]  = '{"nominal3",  16'd3,    64'd32,            0,  2'd0};
        vecs[1]  = '{"len_ovf",   16'd1000, 64'd32,            0,  2'd1};
        vecs[2]  = '{"bad_entry", 16'd4,    64'd36,            0,  2'd2};
        vecs[3]  = '{"throttle",  16'd16,   64'd40,            40, 2'd0};
        vecs[4]  = '{"len_zero",  16'd0,    64'd32,            0,  2'd2};
        vecs[5]  = '{"len_993",   16'd993,  64'd32,            0,  2'd1};
        vecs[6]  = '{"ent_last",  16'd8,    64'd39,            0,  2'd0};
        vecs[7]  = '{"ent_end",   16'd8,    64'd40,            0,  2'd2};
        vecs[8]  = '{"ent_low",   16'd8,    64'd31,            0,  2'd2};
        vecs[9]  = '{"ent_high",  16'd5,    64'h1_0000_0020,   0,  2'd2};
        vecs[10] = '{"len_full",  16'd992,  64'd1023,          10, 2'd0};
        vecs[11] = '{"len_one",   16'd1,    64'd32,            50, 2'd0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Nominal image with fixed bytes.
        pay_q = '{8'h30, 8'hF4, 8'h00};
        send_frame(16'd3, 64'd32, 0, 0, -1, 1'b0);
        finish_frame("nominal", 16'd3, 64'd32, 2'd0);

        for (int v = 0; v < 12; v++) begin
            fill_payload(int'(vecs[v].len));
            send_frame(vecs[v].len, vecs[v].entry, vecs[v].gap, 0, -1, 1'b0);
            finish_frame(vecs[v].name, vecs[v].len, vecs[v].entry, vecs[v].exp_err);
        end

        // Restart while mid-frame must be ignored.
        fill_payload(2);
        send_frame(16'd2, 64'd33, 0, 0, 4, 1'b0);
        finish_frame("restart_ignored", 16'd2, 64'd33, 2'd0);

        // Reset after two of five payload bytes, then a clean frame.
        fill_payload(5);
        send_frame(16'd5, 64'd32, 0, 0, 12, 1'b1);
        fill_payload(5);
        send_frame(16'd5, 64'd34, 0, 0, -1, 1'b0);
        finish_frame("after_reset", 16'd5, 64'd34, 2'd0);

`ifdef IMEM_LOADER_CKSUM_EN
        pay_q = '{8'h30, 8'hF4, 8'h00};
        send_frame(16'd3, 64'd32, 0, 0, -1, 1'b0);
        finish_frame("cksum_ok", 16'd3, 64'd32, 2'd0);
        pay_q = '{8'h30, 8'hF4, 8'h00};
        send_frame(16'd3, 64'd32, 0, 1, -1, 1'b0);
        finish_frame("cksum_bad", 16'd3, 64'd32, 2'd3);
`endif

        for (int r = 0; r < 10; r++) begin
            rlen = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(985, 1000))
                                               : 16'($urandom_range(0, 24));
            mode = int'($urandom_range(0, 3));
            if (mode == 0)      rentry = 64'($urandom_range(0, 31));
            else if (mode == 1) rentry = 64'(LOAD_BASE) + 64'(rlen) + 64'($urandom_range(0, 5));
            else if (rlen == 16'd0) rentry = 64'(LOAD_BASE);
            else rentry = 64'(LOAD_BASE) + 64'($urandom_range(0, int'(rlen) - 1));
            fill_payload(int'(rlen));
            send_frame(rlen, rentry, int'($urandom_range(0, 30)), 0, -1, 1'b0);
            finish_frame($sformatf("rand%0d", r), rlen, rentry, model_err(rlen, rentry));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream of the SEQ processor top: streams a Y86 program image byte-by-byte into the byte-addressed instruction memory, then releases the core with its entry PC.
- Accepts a framed byte stream on a valid/ready handshake. Drives the memory write port. Holds the core (run=0) until the image is complete and valid.
- Frame layout: LEN (2 bytes, little-endian) | ENTRY (8 bytes, little-endian) | PAYLOAD (LEN bytes) [| CKSUM (1 byte), optional].

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes.
- LOAD_BASE, 32, byte address where PAYLOAD[0] is written.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- restart  in  1  single-cycle pulse; re-arms the loader from DONE/ERR.
- mem_we  out  1  write strobe to instruction memory.
- mem_addr  out  64  write byte address.
- mem_wdata  out  8  write byte.
- run  out  1  core enable; the core's PC is loaded from start_pc while run=0.
- start_pc  out  64  entry PC captured from the frame.
- bytes_loaded  out  16  payload bytes written so far.
- load_err  out  1  sticky error flag.
- err_code  out  2  0=none, 1=length overflow, 2=entry out of range, 3=checksum mismatch.

Behaviour:
- Reset (asynchronous): state=LEN, byte counter=0, every output 0 except in_ready=1.
- A byte transfers when in_valid && in_ready at the rising clk edge.
- in_ready=1 in LEN, ENTRY, DATA and CKSUM. in_ready=0 in DONE and ERR.
- LEN:
  - Shifts 2 bytes in LE order into len.
  - After byte 2, if LOAD_BASE+len > MEM_BYTES: go to ERR with code 1.
  - Otherwise go to ENTRY.
- ENTRY:
  - Shifts 8 bytes in LE order into start_pc.
  - After byte 8, if start_pc < LOAD_BASE or start_pc >= LOAD_BASE+len: go to ERR with code 2.
  - Otherwise go to DATA, or skip directly to CKSUM/DONE if len=0. The len=0 case always fails the range check and so goes to ERR code 2.
- DATA:
  - Each accepted byte k (k=0..len-1) produces mem_we=1, mem_addr=LOAD_BASE+k, mem_wdata=byte, registered on the cycle after acceptance (1-cycle latency). mem_we is low otherwise.
  - bytes_loaded increments in the same cycle as mem_we.
  - After byte len-1, go to CKSUM (feature on) or DONE.
- DONE: run=1, held indefinitely. start_pc stable.
- ERR: run=0, load_err=1, err_code held.
- restart in DONE or ERR:
  - Next cycle: state=LEN, run=0, load_err=0, err_code=0, bytes_loaded=0.
  - Memory contents are not cleared.
  - restart is ignored in other states.
- Back-to-back bytes every cycle are sustained. Gaps (in_valid=0) stall without state change.
- Reset asserted mid-frame aborts immediately. The partial image stays in memory, run=0.
- Address arithmetic is 64-bit unsigned. len is 16-bit. The overflow check is computed at 17+ bits so it never wraps.

Optional Feature:
- Macro IMEM_LOADER_CKSUM_EN.
- Defined:
  - After PAYLOAD, one CKSUM byte is accepted.
  - The running 8-bit sum over LEN, ENTRY and PAYLOAD bytes plus CKSUM must equal 8'h00 mod 256.
  - Match: go to DONE. Mismatch: go to ERR code 3.
- Undefined:
  - No CKSUM state; DATA goes directly to DONE.
  - err_code 3 is never produced.

Decomposition:
- Shared package y86_pkg holds:
  - the state enum (LEN, ENTRY, DATA, CKSUM, DONE, ERR);
  - err_code constants (ERR_NONE, ERR_LEN, ERR_ENTRY, ERR_CKSUM);
  - header size constants (LEN_BYTES=2, ENTRY_BYTES=8).
- One natural sub-module, le_shift_capture: a parameterised little-endian byte accumulator with a byte counter and a done pulse, instantiated for the LEN and ENTRY fields.

Test Plan:
- Nominal load:
  - Stimulus: frame LEN=3, ENTRY=32, payload 30 F4 00.
  - Required: mem writes at 32,33,34 with those bytes, each one cycle after acceptance; bytes_loaded=3; run=1; start_pc=32; load_err=0.
- Length overflow:
  - Stimulus: LEN=1000 with MEM_BYTES=1024, LOAD_BASE=32.
  - Required: ERR, err_code=1, in_ready=0, no mem_we pulses, run=0.
- Bad entry:
  - Stimulus: LEN=4, ENTRY=36.
  - Required: ERR, err_code=2. Then a restart pulse followed by a valid frame reaches DONE.
- Throttled stream:
  - Stimulus: random in_valid gaps across a 16-byte payload.
  - Required: writes are exactly the 16 bytes in order at addresses 32..47; no duplicate or missing mem_we.
- Reset mid-DATA:
  - Stimulus: assert reset after 2 of 5 payload bytes.
  - Required: immediately all outputs 0 and in_ready=1. Then a full new frame loads correctly.
- Checksum (IMEM_LOADER_CKSUM_EN defined):
  - Stimulus: nominal frame with correct CKSUM.
  - Required: DONE.
  - Stimulus: CKSUM off by one.
  - Required: ERR, err_code=3, run=0.
